riscv_uart_programmer: RTL and testbench



---
 rtl/riscv_uart_programmer_pkg.sv | 32 +++
 rtl/riscv_uart_programmer_rx.sv | 128 ++++++++++++
 rtl/riscv_uart_programmer.sv | 209 ++++++++++++++++++++
 tb/tb_riscv_uart_programmer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_uart_programmer_pkg.sv
// -----------------------------------------------------------------------------
// riscv_uart_programmer_pkg
//   Shared constants and state encodings for the UART programmer: the frame
//   sync byte, the default word-address width, and the state enums of the
//   byte receiver and the frame parser.
// -----------------------------------------------------------------------------
package riscv_uart_programmer_pkg;

    localparam logic [7:0] UPG_SYNC_BYTE = 8'h5A;
    localparam int unsigned UPG_ADDR_W   = 14;

    // Byte receiver: INIT waits for one full bit of idle-high line.
    typedef enum logic [2:0] {
        RX_INIT,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Frame parser. DONE and ERR behave as IDLE but record the outcome.
    typedef enum logic [2:0] {
        FR_IDLE,
        FR_LEN_LO,
        FR_LEN_HI,
        FR_DATA,
        FR_CSUM,
        FR_DONE,
        FR_ERR
    } frame_state_e;

endpackage

// File: rtl/riscv_uart_programmer_rx.sv
// -----------------------------------------------------------------------------
// riscv_uart_programmer_rx
//   8N1 byte receiver with a 2-FF input synchroniser.
// Ports:
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   rx_i          in   asynchronous serial line, idle high
//   byte_valid_o  out  one-cycle pulse, byte_o holds a correctly framed byte
//   byte_o        out  received byte (LSB first on the line)
//   frame_err_o   out  one-cycle pulse, stop bit sampled low; byte dropped
// -----------------------------------------------------------------------------
module riscv_uart_programmer_rx
    import riscv_uart_programmer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int unsigned     CNT_W   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    assign rx_s   = sync_q[1];
    assign byte_o = shift_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_INIT;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            // Two flops in series keep metastability off the bit-timing logic.
            sync_q  <= {sync_q[0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here is defaulted first; a path that
        // left one unassigned would infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;

        case (state_q)
            RX_INIT: begin
                // Any low sample restarts the idle-high qualification.
                if (!rx_s) begin
                    cnt_d = '0;
                end else if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // High at mid-start means a glitch: back to hunting.
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_valid_o = 1'b1;
                        state_d      = RX_IDLE;
                    end else begin
                        // Line is still low: requalify idle before hunting
                        // so a held break does not retrigger endlessly.
                        frame_err_o = 1'b1;
                        state_d     = RX_INIT;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_INIT;
        endcase
    end

endmodule

// File: rtl/riscv_uart_programmer.sv
// -----------------------------------------------------------------------------
// riscv_uart_programmer
//   Loads a framed image received over UART into memory through the upg_*
//   write interface. Frame: 0x5A, LEN_LO, LEN_HI (N words), 4*N data bytes
//   little-endian, CSUM (8-bit wrapping sum of the data bytes).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   uart_rx_i   in   asynchronous serial input, idle high
//   upg_rst_o   out  high from sync byte until DONE/ERR (holds CPU in reset)
//   upg_wen_o   out  one-cycle word write strobe
//   upg_adr_o   out  word address, valid with upg_wen_o
//   upg_dat_o   out  write data, valid with upg_wen_o
//   upg_done_o  out  image loaded with good checksum; sticky until next sync
//   upg_err_o   out  frame failed; sticky until next sync
// -----------------------------------------------------------------------------
module riscv_uart_programmer
    import riscv_uart_programmer_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = 10_000_000,
    parameter int unsigned BAUD         = 115_200,
    parameter int unsigned ADDR_W       = UPG_ADDR_W,
    parameter int unsigned TIMEOUT_BITS = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    output logic              upg_rst_o,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned TMO_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned TMO_W        = $clog2(TMO_CLKS + 1);
    localparam int unsigned ADR_W        = ADDR_W + 1;  // can reach 2**ADDR_W
    localparam logic [31:0] MAX_WORDS    = 32'd1 << ADDR_W;

    logic       rx_valid, rx_ferr;
    logic [7:0] rx_byte;

    riscv_uart_programmer_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (uart_rx_i),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_ferr)
    );

    frame_state_e state_q, state_d;
    logic [15:0]  len_q, len_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [7:0]   csum_q, csum_d;
    logic [23:0]  word_q, word_d;
    logic [1:0]   bidx_q, bidx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic         rst_q, rst_d, wen_q, wen_d, done_q, done_d, err_q, err_d;
    logic [31:0]  dat_q, dat_d;
    logic [15:0]  n_words;
    logic         in_frame;

    assign n_words  = {rx_byte, len_q[7:0]};
    assign in_frame = (state_q == FR_LEN_LO) || (state_q == FR_LEN_HI) ||
                      (state_q == FR_DATA)   || (state_q == FR_CSUM);

    assign upg_rst_o  = rst_q;
    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q[ADDR_W-1:0];
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FR_IDLE;
            len_q   <= '0;
            adr_q   <= '0;
            csum_q  <= '0;
            word_q  <= '0;
            bidx_q  <= '0;
            tmo_q   <= '0;
            rst_q   <= 1'b0;
            wen_q   <= 1'b0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            adr_q   <= adr_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            bidx_q  <= bidx_d;
            tmo_q   <= tmo_d;
            rst_q   <= rst_d;
            wen_q   <= wen_d;
            dat_q   <= dat_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        adr_d   = adr_q;
        csum_d  = csum_q;
        word_d  = word_q;
        bidx_d  = bidx_q;
        rst_d   = rst_q;
        wen_d   = 1'b0;
        dat_d   = dat_q;
        done_d  = done_q;
        err_d   = err_q;

        // Address advances in the cycle after the strobe it qualified.
        if (wen_q) begin
            adr_d = adr_q + 1'b1;
        end

        // Inter-byte timeout only runs while a frame is open.
        if (in_frame && !rx_valid) begin
            tmo_d = tmo_q + 1'b1;
        end else begin
            tmo_d = '0;
        end

        case (state_q)
            FR_IDLE, FR_DONE, FR_ERR: begin
                if (rx_valid && rx_byte == UPG_SYNC_BYTE) begin
                    state_d = FR_LEN_LO;
                    rst_d   = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    adr_d   = '0;
                    csum_d  = '0;
                    bidx_d  = '0;
                end
            end
            FR_LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_byte;
                    state_d    = FR_LEN_HI;
                end
            end
            FR_LEN_HI: begin
                if (rx_valid) begin
                    len_d = n_words;
                    if (32'(n_words) > MAX_WORDS) begin
                        state_d = FR_ERR;
                        err_d   = 1'b1;
                        rst_d   = 1'b0;
                    end else if (n_words == 16'd0) begin
                        state_d = FR_CSUM;
                    end else begin
                        state_d = FR_DATA;
                    end
                end
            end
            FR_DATA: begin
                if (rx_valid) begin
                    csum_d = csum_q + rx_byte;
                    bidx_d = bidx_q + 1'b1;
                    case (bidx_q)
                        2'd0: word_d[7:0]   = rx_byte;
                        2'd1: word_d[15:8]  = rx_byte;
                        2'd2: word_d[23:16] = rx_byte;
                        default: begin
                            wen_d = 1'b1;
                            dat_d = {rx_byte, word_q};
                            // adr_q still indexes the word being completed.
                            if ((adr_q + 1'b1) == ADR_W'(len_q)) begin
                                state_d = FR_CSUM;
                            end
                        end
                    endcase
                end
            end
            FR_CSUM: begin
                if (rx_valid) begin
                    rst_d = 1'b0;
                    if (rx_byte == csum_q) begin
                        state_d = FR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FR_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = FR_IDLE;
        endcase

        // Line errors and silence abort an open frame and suppress any strobe.
        if (in_frame && (rx_ferr || (!rx_valid && tmo_q == TMO_W'(TMO_CLKS - 1)))) begin
            state_d = FR_ERR;
            err_d   = 1'b1;
            rst_d   = 1'b0;
            wen_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_uart_programmer.sv
// -----------------------------------------------------------------------------
// tb_riscv_uart_programmer
//   Directed bench: serial frames are bit-banged at 10 clk/bit, write strobes
//   are logged by a monitor, and outputs are compared with hand-computed
//   values through check().
// -----------------------------------------------------------------------------
module tb_riscv_uart_programmer;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx_i = 1'b1;
    logic        upg_rst_o, upg_wen_o, upg_done_o, upg_err_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;

    riscv_uart_programmer #(
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .ADDR_W       (14),
        .TIMEOUT_BITS (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx_i  (uart_rx_i),
        .upg_rst_o  (upg_rst_o),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .upg_err_o  (upg_err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Write log, filled only by the monitor.
    int          wr_cnt = 0;
    logic [13:0] wr_adr [64];
    logic [31:0] wr_dat [64];

    always @(negedge clk) begin
        if (upg_wen_o && wr_cnt < 64) begin
            wr_adr[wr_cnt] = upg_adr_o;
            wr_dat[wr_cnt] = upg_dat_o;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx_i = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        uart_rx_i = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        uart_rx_i = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rst"},  32'(upg_rst_o),  32'd0);
        check({tag, ".wen"},  32'(upg_wen_o),  32'd0);
        check({tag, ".adr"},  32'(upg_adr_o),  32'd0);
        check({tag, ".dat"},  upg_dat_o,       32'd0);
        check({tag, ".done"}, 32'(upg_done_o), 32'd0);
        check({tag, ".err"},  32'(upg_err_o),  32'd0);
    endtask

    logic [7:0] good_frame [12] = '{8'h5A, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34,
                                    8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};

    initial begin
        int base;

        // ---- reset ----
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_bits(2);

        // ---- good frame ----
        base = wr_cnt;
        send_byte(good_frame[0], 1'b1);
        idle_bits(1);
        check("good.rst_after_sync", 32'(upg_rst_o), 32'd1);
        for (int i = 1; i < 12; i++) send_byte(good_frame[i], 1'b1);
        idle_bits(1);
        check("good.wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("good.adr0", 32'(wr_adr[base]), 32'd0);
        check("good.dat0", wr_dat[base], 32'h12345678);
        check("good.adr1", 32'(wr_adr[base+1]), 32'd1);
        check("good.dat1", wr_dat[base+1], 32'hDEADBEEF);
        check("good.done", 32'(upg_done_o), 32'd1);
        check("good.err", 32'(upg_err_o), 32'd0);
        check("good.rst", 32'(upg_rst_o), 32'd0);

        // ---- bad checksum ----
        base = wr_cnt;
        for (int i = 0; i < 11; i++) send_byte(good_frame[i], 1'b1);
        send_byte(8'h4D, 1'b1);
        idle_bits(1);
        check("csum.wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("csum.dat1", wr_dat[base+1], 32'hDEADBEEF);
        check("csum.err", 32'(upg_err_o), 32'd1);
        check("csum.done", 32'(upg_done_o), 32'd0);
        check("csum.rst", 32'(upg_rst_o), 32'd0);

        // ---- stop bit low on 0x34 ----
        base = wr_cnt;
        for (int i = 0; i < 5; i++) send_byte(good_frame[i], 1'b1);
        send_byte(8'h34, 1'b0);
        idle_bits(2);
        check("ferr.err", 32'(upg_err_o), 32'd1);
        check("ferr.rst", 32'(upg_rst_o), 32'd0);
        for (int i = 6; i < 12; i++) send_byte(good_frame[i], 1'b1);
        idle_bits(1);
        check("ferr.wr_cnt", 32'(wr_cnt - base), 32'd0);
        check("ferr.err_sticky", 32'(upg_err_o), 32'd1);
        check("ferr.done", 32'(upg_done_o), 32'd0);

        // ---- oversize length 0x4001 ----
        base = wr_cnt;
        send_byte(8'h5A, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h40, 1'b1);
        idle_bits(1);
        check("len.err", 32'(upg_err_o), 32'd1);
        check("len.rst", 32'(upg_rst_o), 32'd0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        idle_bits(1);
        check("len.wr_cnt", 32'(wr_cnt - base), 32'd0);

        // ---- N=0 frame with a 4-clk glitch after LEN_LO ----
        base = wr_cnt;
        send_byte(8'h5A, 1'b1);
        send_byte(8'h00, 1'b1);
        uart_rx_i = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(3);
        check("glitch.err", 32'(upg_err_o), 32'd0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        idle_bits(1);
        check("n0.done", 32'(upg_done_o), 32'd1);
        check("n0.err", 32'(upg_err_o), 32'd0);
        check("n0.wr_cnt", 32'(wr_cnt - base), 32'd0);

        // ---- timeout after sync byte ----
        send_byte(8'h5A, 1'b1);
        idle_bits(500);
        check("tmo.err_early", 32'(upg_err_o), 32'd0);
        check("tmo.rst_early", 32'(upg_rst_o), 32'd1);
        idle_bits(600);
        check("tmo.err", 32'(upg_err_o), 32'd1);
        check("tmo.rst", 32'(upg_rst_o), 32'd0);

        // ---- reset in the middle of DATA ----
        base = wr_cnt;
        for (int i = 0; i < 6; i++) send_byte(good_frame[i], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        idle_bits(2);
        check("midrst.wr_cnt", 32'(wr_cnt - base), 32'd0);

        base = wr_cnt;
        for (int i = 0; i < 12; i++) send_byte(good_frame[i], 1'b1);
        idle_bits(1);
        check("again.wr_cnt", 32'(wr_cnt - base), 32'd2);
        check("again.dat0", wr_dat[base], 32'h12345678);
        check("again.adr1", 32'(wr_adr[base+1]), 32'd1);
        check("again.done", 32'(upg_done_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
